// File: rtl/axi2mem_pkg.sv
// Shared AXI read-channel types, response codes and FSM state encoding
// for the AXI-to-memory read bridge.
package axi2mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } axi_burst_t;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } state_t;

  // A burst is served from memory only if its beat size fits the data bus,
  // its burst type is defined, and a WRAP burst has 2, 4, 8 or 16 beats.
  function automatic logic burst_is_legal(input logic [2:0] size,
                                          input logic [7:0] len,
                                          input axi_burst_t burst,
                                          input logic [2:0] max_size);
    logic legal;
    legal = 1'b1;
    if (size > max_size) legal = 1'b0;
    if (burst == BURST_RESERVED) legal = 1'b0;
    if (burst == BURST_WRAP &&
        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) legal = 1'b0;
    return legal;
  endfunction

endpackage

// File: rtl/axi2mem_burst_addr_gen.sv
// Combinational byte address of a given beat within an AXI burst
// (FIXED, INCR and WRAP); RESERVED bursts just return the start address.
module axi2mem_burst_addr_gen
  import axi2mem_pkg::*;
#(
  parameter int wd_addr = 64
) (
  input  logic [wd_addr-1:0] start_addr,
  input  logic [2:0]         size,
  input  logic [7:0]         len,
  input  axi_burst_t         burst,
  input  logic [7:0]         beat,
  output logic [wd_addr-1:0] beat_addr
);

  logic [wd_addr-1:0] size_mask;
  logic [wd_addr-1:0] wrap_mask;
  logic [wd_addr-1:0] step;
  logic [wd_addr-1:0] incr_addr;
  logic [wd_addr-1:0] wrap_addr;

  // Select the beat address according to the burst type.
  always_comb begin
    size_mask = (wd_addr'(1) << size) - wd_addr'(1);
    wrap_mask = ((wd_addr'(len) + wd_addr'(1)) << size) - wd_addr'(1);
    step      = wd_addr'(beat) << size;
    // Only the first INCR beat may be unaligned; later beats step from the
    // size-aligned start and roll over naturally at the top of the space.
    incr_addr = (beat == 8'd0) ? start_addr : ((start_addr & ~size_mask) + step);
    // WRAP keeps the high bits of the wrap-aligned base and lets only the
    // offset inside the wrap window advance.
    wrap_addr = (start_addr & ~wrap_mask) | ((start_addr + step) & wrap_mask);
    case (burst)
      BURST_INCR: beat_addr = incr_addr;
      BURST_WRAP: beat_addr = wrap_addr;
      default:    beat_addr = start_addr;
    endcase
  end

endmodule

// File: rtl/axi2mem_rd_channel.sv
// AXI read channel to single-beat memory bridge: accepts one AR burst at a
// time and turns each beat into one memory request/response pair.
module axi2mem_rd_channel
  import axi2mem_pkg::*;
#(
  parameter int wd_addr = 64,
  parameter int wd_data = 64,
  parameter int wd_id   = 4,
  parameter int wd_user = 1
) (
  input  logic               clk,
  input  logic               rst,
  // AR channel
  input  logic               ar_valid,
  output logic               ar_ready,
  input  logic [wd_addr-1:0] ar_addr,
  input  logic [7:0]         ar_len,
  input  logic [2:0]         ar_size,
  input  axi_burst_t         ar_burst,
  input  logic [wd_id-1:0]   ar_id,
  input  logic [wd_user-1:0] ar_user,
  // R channel
  output logic               r_valid,
  input  logic               r_ready,
  output logic [wd_data-1:0] r_data,
  output logic               r_last,
  output logic [wd_id-1:0]   r_id,
  output axi_resp_t          r_resp,
  output logic [wd_user-1:0] r_user,
  // memory request
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [wd_addr-1:0] mem_addr,
  // memory response
  input  logic               mem_rvalid,
  input  logic [wd_data-1:0] mem_rdata,
  input  logic               mem_rerr
);

  localparam int         wd_strb  = wd_data / 8;
  localparam logic [2:0] max_size = 3'($clog2(wd_strb));

  state_t             state_q;
  state_t             state_d;

  logic [wd_addr-1:0] addr_q;
  logic [7:0]         len_q;
  logic [2:0]         size_q;
  axi_burst_t         burst_q;
  logic [wd_id-1:0]   id_q;
  logic [wd_user-1:0] user_q;
  logic [7:0]         beat_q;
  logic               illegal_q;
  logic [wd_data-1:0] data_q;
  axi_resp_t          resp_q;

  logic               last_beat;
  logic [wd_addr-1:0] beat_addr;

  assign last_beat = (beat_q == len_q);

  axi2mem_burst_addr_gen #(
    .wd_addr (wd_addr)
  ) u_addr_gen (
    .start_addr (addr_q),
    .size       (size_q),
    .len        (len_q),
    .burst      (burst_q),
    .beat       (beat_q),
    .beat_addr  (beat_addr)
  );

  // Memory is word-addressed: drop the byte-lane bits of the beat address.
  assign mem_addr = beat_addr & ~wd_addr'(wd_strb - 1);

  assign r_data = data_q;
  assign r_resp = resp_q;
  assign r_id   = id_q;
  assign r_user = user_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // together from the values sampled at this edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a value
    // unassigned and infers a latch.
    state_d  = state_q;
    ar_ready = 1'b0;
    mem_req  = 1'b0;
    r_valid  = 1'b0;
    r_last   = 1'b0;
    case (state_q)
      IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) state_d = REQ;
      end
      REQ: begin
        // Illegal bursts never touch memory; each beat goes straight to RESP.
        mem_req = !illegal_q;
        if (illegal_q)    state_d = RESP;
        else if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_d = RESP;
      end
      RESP: begin
        r_valid = 1'b1;
        r_last  = last_beat;
        if (r_ready) state_d = last_beat ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst context, beat counter and registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      id_q      <= '0;
      user_q    <= '0;
      beat_q    <= '0;
      illegal_q <= 1'b0;
      data_q    <= '0;
      resp_q    <= AXI_RESP_OKAY;
    end else begin
      if (state_q == IDLE && ar_valid) begin
        addr_q    <= ar_addr;
        len_q     <= ar_len;
        size_q    <= ar_size;
        burst_q   <= ar_burst;
        id_q      <= ar_id;
        user_q    <= ar_user;
        beat_q    <= '0;
        illegal_q <= !burst_is_legal(ar_size, ar_len, ar_burst, max_size);
      end
      if (state_q == REQ && illegal_q) begin
        data_q <= '0;
        resp_q <= AXI_RESP_SLVERR;
      end
      if (state_q == WAIT && mem_rvalid) begin
        data_q <= mem_rdata;
        resp_q <= mem_rerr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (state_q == RESP && r_ready && !last_beat) beat_q <= beat_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi2mem_rd_channel.sv
// Self-checking bench for axi2mem_rd_channel: directed bursts for the
// documented corner cases followed by randomized bursts against a
// behavioural address/response model.
module tb_axi2mem_rd_channel;
  import axi2mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  axi_burst_t  ar_burst;
  logic [3:0]  ar_id;
  logic [0:0]  ar_user;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic        r_last;
  logic [3:0]  r_id;
  axi_resp_t   r_resp;
  logic [0:0]  r_user;
  logic        mem_req;
  logic        mem_gnt;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_rerr;

  int          checks = 0;
  int          errors = 0;
  int unsigned cycle = 0;
  int unsigned req_cycles = 0;
  int unsigned grants = 0;

  axi2mem_rd_channel #(
    .wd_addr (64),
    .wd_data (64),
    .wd_id   (4),
    .wd_user (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .ar_addr    (ar_addr),
    .ar_len     (ar_len),
    .ar_size    (ar_size),
    .ar_burst   (ar_burst),
    .ar_id      (ar_id),
    .ar_user    (ar_user),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_last     (r_last),
    .r_id       (r_id),
    .r_resp     (r_resp),
    .r_user     (r_user),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rerr   (mem_rerr)
  );

  always #5 clk = ~clk;

  // Cycle counter and memory-side activity counters.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (mem_req && mem_gnt) grants <= grants + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference beat address from the burst rules, in plain byte arithmetic.
  function automatic logic [63:0] model_addr(input logic [63:0] addr, input int size,
                                             input int len, input int burst, input int n);
    logic [63:0] bytes, wl, base;
    bytes = 64'd1 << size;
    case (burst)
      1: model_addr = (n == 0) ? addr : (addr / bytes) * bytes + 64'(n) * bytes;
      2: begin
        wl   = bytes * 64'(len + 1);
        base = (addr / wl) * wl;
        model_addr = base + ((addr - base + 64'(n) * bytes) % wl);
      end
      default: model_addr = addr;
    endcase
  endfunction

  function automatic bit model_legal(input int size, input int len, input int burst);
    if (size > 3) return 0;
    if (burst == 3) return 0;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 0;
    return 1;
  endfunction

  // Memory content: a fixed function of the word address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  // Run one burst: memory responder and R-channel checker in parallel.
  task automatic do_burst(input logic [63:0] addr, input int len, input int size,
                          input int burst, input logic [255:0] err, input int max_gd,
                          input int max_rd, input int max_stall, input bit chk_lat,
                          input int bp0);
    logic [3:0]  id;
    logic [0:0]  user;
    bit          legal;
    int unsigned req0, gnt0, hs_cyc;
    id    = 4'($urandom);
    user  = 1'($urandom);
    legal = model_legal(size, len, burst);
    @(negedge clk);
    check("ar_ready_idle", ar_ready, 1);
    ar_addr  = addr;
    ar_len   = 8'(len);
    ar_size  = 3'(size);
    ar_burst = axi_burst_t'(2'(burst));
    ar_id    = id;
    ar_user  = user;
    ar_valid = 1'b1;
    req0     = req_cycles;
    gnt0     = grants;
    @(negedge clk);
    ar_valid = 1'b0;
    ar_addr  = {$urandom, $urandom};
    hs_cyc   = cycle;
    check("ar_ready_busy", ar_ready, 0);
    fork
      begin : mem_side
        if (legal) begin
          for (int n = 0; n <= len; n++) begin
            logic [63:0] ea;
            int t;
            t = 0;
            while (mem_req !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            check("mem_req_seen", mem_req, 1);
            ea = model_addr(addr, size, len, burst, n) & ~64'h7;
            check("mem_addr", mem_addr, ea);
            repeat ($urandom_range(max_gd, 0)) begin
              @(negedge clk);
              check("mem_addr_hold", mem_addr, ea);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            repeat ($urandom_range(max_rd, 0)) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(ea);
            mem_rerr   = err[n];
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rerr   = 1'b0;
            mem_rdata  = {$urandom, $urandom};
          end
        end
      end
      begin : r_side
        for (int n = 0; n <= len; n++) begin
          logic [63:0] d0, ea;
          int t, stall;
          t = 0;
          while (r_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
          check("r_valid_seen", r_valid, 1);
          if (n == 0 && chk_lat) check("min_latency", 64'(cycle - hs_cyc), 64'd2);
          stall = (n == 0 && bp0 > 0) ? bp0 : $urandom_range(max_stall, 0);
          d0 = r_data;
          repeat (stall) begin
            @(negedge clk);
            check("r_valid_held", r_valid, 1);
            check("r_data_stable", r_data, d0);
            if (bp0 > 0 && n == 0) begin
              check("bp_no_mem_req", mem_req, 0);
              check("bp_ar_ready", ar_ready, 0);
            end
          end
          ea = model_addr(addr, size, len, burst, n) & ~64'h7;
          check("r_last", r_last, (n == len) ? 1 : 0);
          check("r_id", r_id, id);
          check("r_user", r_user, user);
          if (legal) begin
            check("r_resp", r_resp, err[n] ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
            check("r_data", r_data, mem_word(ea));
          end else begin
            check("r_resp_illegal", r_resp, AXI_RESP_SLVERR);
          end
          r_ready = 1'b1;
          @(negedge clk);
          r_ready = 1'b0;
        end
      end
    join
    check("burst_end_r_valid", r_valid, 0);
    check("burst_end_ar_ready", ar_ready, 1);
    if (legal) check("grant_count", 64'(grants - gnt0), 64'(len + 1));
    else       check("no_mem_req", 64'(req_cycles - req0), 64'd0);
  endtask

  initial begin
    logic [255:0] err;
    logic [63:0]  a;
    int           len, size, burst, pick;

    rst        = 1'b1;
    ar_valid   = 1'b0;
    ar_addr    = '0;
    ar_len     = '0;
    ar_size    = '0;
    ar_burst   = BURST_FIXED;
    ar_id      = '0;
    ar_user    = '0;
    r_ready    = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_rerr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_ar_ready", ar_ready, 1);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_last", r_last, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_r_data", r_data, 0);
    check("rst_r_id", r_id, 0);
    check("rst_r_user", r_user, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_r_resp", r_resp, AXI_RESP_OKAY);

    // INCR, unaligned start, minimum latency on the first beat.
    do_burst(64'h1004, 3, 2, 1, '0, 0, 0, 0, 1'b1, 0);
    // WRAP crossing the region boundary, then an illegal WRAP length.
    do_burst(64'h38, 3, 3, 2, '0, 1, 1, 1, 1'b0, 0);
    do_burst(64'h38, 2, 3, 2, '0, 1, 1, 1, 1'b0, 0);
    // FIXED with a memory error on the second beat only.
    err = '0;
    err[1] = 1'b1;
    do_burst(64'h2000, 1, 3, 0, err, 2, 2, 1, 1'b0, 0);
    // Backpressure: beat 0 held for five cycles.
    do_burst(64'h3008, 1, 3, 1, '0, 0, 0, 0, 1'b0, 5);

    // Reset while waiting for memory, response arriving one cycle late.
    @(negedge clk);
    ar_addr  = 64'h100;
    ar_len   = 8'd0;
    ar_size  = 3'd3;
    ar_burst = BURST_FIXED;
    ar_id    = 4'h9;
    ar_user  = 1'b1;
    ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    check("mid_rst_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_0000_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_r_valid", r_valid, 0);
      check("mid_rst_ar_ready", ar_ready, 1);
      check("mid_rst_mem_req", mem_req, 0);
      @(negedge clk);
    end
    do_burst(64'h4010, 2, 3, 1, '0, 1, 1, 1, 1'b0, 0);

    // Randomized bursts, legal and illegal, including top-of-space starts.
    for (int k = 0; k < 40; k++) begin
      burst = $urandom_range(3, 0);
      size  = ($urandom_range(7, 0) == 0) ? 4 : $urandom_range(3, 0);
      pick  = $urandom_range(6, 0);
      case (pick)
        0: len = 0;
        1: len = 1;
        2: len = 2;
        3: len = 3;
        4: len = 7;
        5: len = 15;
        default: len = $urandom_range(20, 0);
      endcase
      a = {$urandom, $urandom};
      if ($urandom_range(7, 0) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      err = '0;
      for (int i = 0; i < 32; i++) err[i] = ($urandom_range(3, 0) == 0);
      do_burst(a, len, size, burst, err, 2, 2, 2, 1'b0, 0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi2mem_rd_channel.md
AXI2MEM_RD_CHANNEL -- requirements
Module: axi2mem_rd_channel

Interface
REQ-001 SHALL have parameter wd_addr, default 64, address width in bits.
REQ-002 SHALL have parameter wd_data, default 64, R/memory data width; a power of two and at least 8.
REQ-003 SHALL have parameter wd_id, default 4, AR/R ID width.
REQ-004 SHALL have parameter wd_user, default 1, AR/R user width; derived localparam wd_strb = wd_data/8.
REQ-005 SHALL have port clk, in, 1, sole clock; all logic updates on its rising edge.
REQ-006 SHALL have port rst, in, 1, reset; synchronous and active-high.
REQ-007 SHALL have ports ar_valid, in, 1, and ar_ready, out, 1: AR handshake.
REQ-008 SHALL have ports ar_addr, in, wd_addr; ar_len, in, 8; ar_size, in, 3; ar_burst, in, axi_burst_t; ar_id, in, wd_id; ar_user, in, wd_user.
REQ-009 SHALL have ports r_valid, out, 1, and r_ready, in, 1: R handshake.
REQ-010 SHALL have ports r_data, out, wd_data; r_last, out, 1; r_id, out, wd_id; r_resp, out, axi_resp_t; r_user, out, wd_user.
REQ-011 SHALL have ports mem_req, out, 1; mem_gnt, in, 1; mem_addr, out, wd_addr: memory read request, accepted when mem_req and mem_gnt are both high.
REQ-012 SHALL have ports mem_rvalid, in, 1; mem_rdata, in, wd_data; mem_rerr, in, 1: memory read response, one per granted request.

Function
REQ-013 SHALL use FSM states IDLE, REQ, WAIT, RESP, and SHALL have one burst outstanding at most.
REQ-014 SHALL drive ar_ready=1 only in IDLE; AR handshake moves IDLE->REQ and latches id, user, len, size, burst and address.
REQ-015 SHALL hold mem_req=1 and mem_addr constant in REQ; when mem_gnt=1, it SHALL move to WAIT.
REQ-016 SHALL move WAIT->RESP on mem_rvalid and register mem_rdata into r_data; r_resp = SLVERR when mem_rerr=1, otherwise OKAY.
REQ-017 SHALL drive r_valid=1 only in RESP, with r_data/r_resp/r_last/r_id/r_user held stable until r_ready=1.
REQ-018 On an R handshake, SHALL go to IDLE if r_last=1, otherwise to REQ with the beat counter incremented.
REQ-019 SHALL assert r_last on beat index ar_len; a burst always returns exactly ar_len+1 beats.
REQ-020 Beat address, FIXED: ar_addr for every beat.
REQ-021 Beat address, INCR: beat 0 = ar_addr; beat n = (ar_addr aligned to 2^ar_size) + n*2^ar_size, wrapping modulo 2^wd_addr.
REQ-022 Beat address, WRAP: wrap length = 2^ar_size*(ar_len+1); beat address stays within the wrap-length-aligned region and wraps to its base.
REQ-023 SHALL drive mem_addr as the beat address with the low log2(wd_strb) bits cleared.
REQ-024 SHALL answer an illegal burst with SLVERR on all ar_len+1 beats and issue no mem_req; illegal = ar_size > log2(wd_strb), burst=RESERVED, or WRAP with ar_len not in {1,3,7,15}.
REQ-025 SHALL ignore mem_rvalid in any state other than WAIT.
REQ-026 SHALL limit minimum per-beat latency to 3 cycles: AR handshake at edge 0, mem_req high after edge 0, r_valid high after edge 2 when mem_gnt=1 and mem_rvalid=1 immediately.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and clear the beat counter; ar_ready=1, r_valid=0, r_last=0, mem_req=0, r_data/r_id/r_user/mem_addr=0, r_resp=OKAY.
REQ-028 Reset in mid-burst SHALL abandon the burst with no further R beats; a late memory response SHALL be dropped per REQ-025.

Structure
REQ-029 axi_burst_t, axi_resp_t and the FSM state enum SHALL live in axi2mem_pkg, together with constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
REQ-030 Beat address computation SHALL be one combinational sub-module, axi2mem_burst_addr_gen (inputs: start addr, size, len, burst, beat index; output: beat addr).

Verification
REQ-031 INCR, wd_data=64, ar_addr=0x1004, size=2, len=3: mem_addr 0x1000,0x1008,0x1008,0x1010; 4 beats OKAY; r_last on beat 3 only.
REQ-032 WRAP, ar_addr=0x38, size=3, len=3: beat addresses 0x38,0x20,0x28,0x30; WRAP with len=2 gives 3 SLVERR beats and no mem_req.
REQ-033 FIXED, len=1, mem_rerr=1 on beat 1 only: beats OKAY then SLVERR; r_id and r_user equal the latched ar_id/ar_user.
REQ-034 Backpressure: r_ready low for 5 cycles on beat 0 of len=1: r_valid held, r_data stable, no mem_req until r_ready=1; ar_ready stays 0 throughout.
REQ-035 rst pulsed one cycle while in WAIT, with mem_rvalid arriving the next cycle: no r_valid; ar_ready=1; the next burst completes normally.
